// File: rtl/store_request_unit.sv
// Store request unit: formats SB/SH/SW/SWL/SWR byte strobes and write data,
// issues a single write on the req/addr_ok/data_ok bus and reports completion
// or a misaligned-store address error.
module store_request_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter bit          CANCEL_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  st_valid,
    input  logic [2:0]            st_op,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [31:0]           st_rt,
    input  logic                  st_cancel,
    output logic                  st_ready,
    output logic                  st_busy,
    output logic                  st_done,
    output logic                  st_ades,
    output logic [ADDR_WIDTH-1:0] st_badvaddr,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [3:0]            data_wstrb,
    output logic [31:0]           data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok
);

    localparam int unsigned AW = ADDR_WIDTH;

    localparam logic [2:0] OP_SW  = 3'b001;
    localparam logic [2:0] OP_SWL = 3'b010;
    localparam logic [2:0] OP_SWR = 3'b011;
    localparam logic [2:0] OP_SB  = 3'b100;
    localparam logic [2:0] OP_SH  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic          cancel_eff;
    logic          op_store;
    logic          misaligned;
    logic          accept;
    logic          ades_set;
    logic          done_set;
    logic          drop;
    logic          drop_next;
    logic [1:0]    off;
    logic [1:0]    fmt_size;
    logic [AW-1:0] fmt_addr;
    logic [3:0]    fmt_wstrb;
    logic [31:0]   fmt_wdata;

    assign cancel_eff = CANCEL_EN && st_cancel;
    assign off        = st_addr[1:0];

    // Status and bus-valid outputs decode directly from the state register.
    assign st_ready = (state == S_IDLE);
    assign st_busy  = (state != S_IDLE);
    assign data_req = (state == S_REQ);
    assign data_wr  = data_req;

    // Decode store type, alignment and the formatted bus request.
    always_comb begin
        op_store   = 1'b0;
        misaligned = 1'b0;
        fmt_size   = 2'd2;
        fmt_addr   = st_addr;
        fmt_wstrb  = 4'b1111;
        fmt_wdata  = st_rt;
        case (st_op)
            OP_SW: begin
                op_store   = 1'b1;
                misaligned = (off != 2'b00);
            end
            OP_SH: begin
                op_store   = 1'b1;
                misaligned = off[0];
                fmt_size   = 2'd1;
                fmt_wstrb  = off[1] ? 4'b1100 : 4'b0011;
                fmt_wdata  = {st_rt[15:0], st_rt[15:0]};
            end
            OP_SB: begin
                op_store  = 1'b1;
                fmt_size  = 2'd0;
                fmt_wstrb = 4'(4'b0001 << off);
                fmt_wdata = {4{st_rt[7:0]}};
            end
            OP_SWL: begin
                op_store = 1'b1;
                fmt_addr = {st_addr[AW-1:2], 2'b00};
                case (off)
                    2'd0: begin fmt_wstrb = 4'b0001; fmt_wdata = {24'b0, st_rt[31:24]}; end
                    2'd1: begin fmt_wstrb = 4'b0011; fmt_wdata = {16'b0, st_rt[31:16]}; end
                    2'd2: begin fmt_wstrb = 4'b0111; fmt_wdata = {8'b0, st_rt[31:8]};   end
                    default: begin fmt_wstrb = 4'b1111; fmt_wdata = st_rt;              end
                endcase
            end
            OP_SWR: begin
                op_store = 1'b1;
                fmt_addr = {st_addr[AW-1:2], 2'b00};
                case (off)
                    2'd0: begin fmt_wstrb = 4'b1111; fmt_wdata = st_rt;                  end
                    2'd1: begin fmt_wstrb = 4'b1110; fmt_wdata = {st_rt[23:0], 8'b0};  end
                    2'd2: begin fmt_wstrb = 4'b1100; fmt_wdata = {st_rt[15:0], 16'b0}; end
                    default: begin fmt_wstrb = 4'b1000; fmt_wdata = {st_rt[7:0], 24'b0}; end
                endcase
            end
            default: op_store = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (st_valid && op_store && !cancel_eff && !misaligned) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (data_addr_ok && data_data_ok) begin
                    state_next = S_IDLE;
                end else if (data_addr_ok) begin
                    state_next = S_RESP;
                end else if (cancel_eff) begin
                    state_next = S_IDLE;
                end
            end
            S_RESP: begin
                if (data_data_ok) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control decode: accept/reject, done pulse and drop flag for cancelled writes.
    always_comb begin
        accept    = 1'b0;
        ades_set  = 1'b0;
        done_set  = 1'b0;
        drop_next = drop;
        case (state)
            S_IDLE: begin
                drop_next = 1'b0;
                if (st_valid && op_store && !cancel_eff) begin
                    ades_set = misaligned;
                    accept   = !misaligned;
                end
            end
            S_REQ: begin
                if (data_addr_ok && data_data_ok) begin
                    done_set  = !cancel_eff;
                    drop_next = 1'b0;
                end else if (data_addr_ok) begin
                    // Write already accepted by the bus; a flush only hides the done.
                    drop_next = cancel_eff;
                end
            end
            S_RESP: begin
                if (cancel_eff) begin
                    drop_next = 1'b1;
                end
                if (data_data_ok) begin
                    done_set  = !drop && !cancel_eff;
                    drop_next = 1'b0;
                end
            end
            default: drop_next = 1'b0;
        endcase
    end

    // Registered pulses, fault address and the held bus request fields.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_done     <= 1'b0;
            st_ades     <= 1'b0;
            st_badvaddr <= '0;
            drop        <= 1'b0;
            data_size   <= 2'd0;
            data_addr   <= '0;
            data_wstrb  <= 4'b0;
            data_wdata  <= 32'b0;
        end else begin
            st_done <= done_set;
            st_ades <= ades_set;
            drop    <= drop_next;
            if (ades_set) begin
                st_badvaddr <= st_addr;
            end
            if (accept) begin
                data_size  <= fmt_size;
                data_addr  <= fmt_addr;
                data_wstrb <= fmt_wstrb;
                data_wdata <= fmt_wdata;
            end
        end
    end

endmodule

// File: tb/tb_store_request_unit.sv
// Directed testbench for store_request_unit.
module tb_store_request_unit;

    localparam int unsigned AW = 32;

    logic          clk;
    logic          resetn;
    logic          st_valid;
    logic [2:0]    st_op;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_rt;
    logic          st_cancel;
    logic          st_ready;
    logic          st_busy;
    logic          st_done;
    logic          st_ades;
    logic [AW-1:0] st_badvaddr;
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [3:0]    data_wstrb;
    logic [31:0]   data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;

    int n_checks;
    int n_fail;

    store_request_unit #(.ADDR_WIDTH(AW), .CANCEL_EN(1'b1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .st_valid     (st_valid),
        .st_op        (st_op),
        .st_addr      (st_addr),
        .st_rt        (st_rt),
        .st_cancel    (st_cancel),
        .st_ready     (st_ready),
        .st_busy      (st_busy),
        .st_done      (st_done),
        .st_ades      (st_ades),
        .st_badvaddr  (st_badvaddr),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one store for a single cycle (unit is idle, so it is accepted).
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] a, input logic [31:0] r);
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = a;
        st_rt    = r;
        step();
        st_valid = 1'b0;
        st_op    = 3'b000;
    endtask

    // Complete the pending write with addr_ok and data_ok together.
    task automatic complete_fast(input string tag);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        check({tag, "_done"}, 64'(st_done), 64'd1);
        check({tag, "_ready"}, 64'(st_ready), 64'd1);
        step();
        check({tag, "_done_clr"}, 64'(st_done), 64'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        resetn       = 1'b0;
        st_valid     = 1'b0;
        st_op        = 3'b000;
        st_addr      = '0;
        st_rt        = 32'h0;
        st_cancel    = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;

        // Reset state
        step();
        step();
        check("rst_ready", 64'(st_ready), 64'd1);
        check("rst_busy", 64'(st_busy), 64'd0);
        check("rst_req", 64'(data_req), 64'd0);
        check("rst_done", 64'(st_done), 64'd0);
        check("rst_ades", 64'(st_ades), 64'd0);
        check("rst_addr", 64'(data_addr), 64'd0);
        resetn = 1'b1;
        step();

        // 1. SW, addr_ok and data_ok each one cycle late
        issue(3'b001, 32'h0000_1000, 32'hDEAD_BEEF);
        check("sw_req", 64'(data_req), 64'd1);
        check("sw_wr", 64'(data_wr), 64'd1);
        check("sw_busy", 64'(st_busy), 64'd1);
        check("sw_ready", 64'(st_ready), 64'd0);
        check("sw_size", 64'(data_size), 64'd2);
        check("sw_addr", 64'(data_addr), 64'h1000);
        check("sw_wstrb", 64'(data_wstrb), 64'hF);
        check("sw_wdata", 64'(data_wdata), 64'hDEAD_BEEF);
        step();
        check("sw_req_hold", 64'(data_req), 64'd1);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check("sw_resp_req", 64'(data_req), 64'd0);
        check("sw_resp_busy", 64'(st_busy), 64'd1);
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        check("sw_done", 64'(st_done), 64'd1);
        check("sw_idle", 64'(st_ready), 64'd1);
        step();
        check("sw_done_clr", 64'(st_done), 64'd0);

        // 2. SB at offset 3
        issue(3'b100, 32'h0000_1003, 32'h0000_00A5);
        check("sb_size", 64'(data_size), 64'd0);
        check("sb_addr", 64'(data_addr), 64'h1003);
        check("sb_wstrb", 64'(data_wstrb), 64'h8);
        check("sb_wdata", 64'(data_wdata), 64'hA5A5_A5A5);
        complete_fast("sb");

        // 3. SWL / SWR at offset 1
        issue(3'b010, 32'h0000_2001, 32'h1122_3344);
        check("swl_size", 64'(data_size), 64'd2);
        check("swl_addr", 64'(data_addr), 64'h2000);
        check("swl_wstrb", 64'(data_wstrb), 64'h3);
        check("swl_wdata", 64'(data_wdata), 64'h0000_1122);
        complete_fast("swl");
        issue(3'b011, 32'h0000_2001, 32'h1122_3344);
        check("swr_addr", 64'(data_addr), 64'h2000);
        check("swr_wstrb", 64'(data_wstrb), 64'hE);
        check("swr_wdata", 64'(data_wdata), 64'h2233_4400);
        complete_fast("swr");

        // SH upper half, SWL offset 3, SWR offset 3
        issue(3'b101, 32'h0000_3002, 32'h1234_BEEF);
        check("sh_size", 64'(data_size), 64'd1);
        check("sh_wstrb", 64'(data_wstrb), 64'hC);
        check("sh_wdata", 64'(data_wdata), 64'hBEEF_BEEF);
        complete_fast("sh");
        issue(3'b010, 32'h0000_2003, 32'h1122_3344);
        check("swl3_wstrb", 64'(data_wstrb), 64'hF);
        check("swl3_wdata", 64'(data_wdata), 64'h1122_3344);
        complete_fast("swl3");
        issue(3'b011, 32'h0000_2003, 32'h1122_3344);
        check("swr3_wstrb", 64'(data_wstrb), 64'h8);
        check("swr3_wdata", 64'(data_wdata), 64'h4400_0000);
        complete_fast("swr3");

        // 4. Misaligned SH and SW
        issue(3'b101, 32'h0000_3001, 32'h0);
        check("sh_ades", 64'(st_ades), 64'd1);
        check("sh_badv", 64'(st_badvaddr), 64'h3001);
        check("sh_noreq", 64'(data_req), 64'd0);
        check("sh_ades_ready", 64'(st_ready), 64'd1);
        step();
        check("sh_ades_clr", 64'(st_ades), 64'd0);
        check("sh_noreq2", 64'(data_req), 64'd0);
        issue(3'b001, 32'h0000_1002, 32'h0);
        check("sw_ades", 64'(st_ades), 64'd1);
        check("sw_badv", 64'(st_badvaddr), 64'h1002);
        check("sw_noreq", 64'(data_req), 64'd0);
        step();

        // Non-store opcode is ignored
        issue(3'b000, 32'h0000_5000, 32'h0);
        check("nop_req", 64'(data_req), 64'd0);
        check("nop_ades", 64'(st_ades), 64'd0);

        // 5a. Cancel in REQ without addr_ok
        issue(3'b001, 32'h0000_4000, 32'h5555_5555);
        check("creq_req", 64'(data_req), 64'd1);
        st_cancel = 1'b1;
        step();
        st_cancel = 1'b0;
        check("creq_ready", 64'(st_ready), 64'd1);
        check("creq_noreq", 64'(data_req), 64'd0);
        check("creq_nodone", 64'(st_done), 64'd0);
        step();
        check("creq_nodone2", 64'(st_done), 64'd0);

        // 5b. Cancel in RESP: waits for data_ok, no done
        issue(3'b001, 32'h0000_4004, 32'h6666_6666);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        st_cancel = 1'b1;
        step();
        st_cancel = 1'b0;
        check("cresp_busy", 64'(st_busy), 64'd1);
        step();
        check("cresp_busy2", 64'(st_busy), 64'd1);
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        check("cresp_ready", 64'(st_ready), 64'd1);
        check("cresp_nodone", 64'(st_done), 64'd0);
        step();
        check("cresp_nodone2", 64'(st_done), 64'd0);

        // Drop flag must not leak into the next transaction
        issue(3'b100, 32'h0000_4008, 32'h0000_0077);
        check("after_wstrb", 64'(data_wstrb), 64'h1);
        check("after_wdata", 64'(data_wdata), 64'h7777_7777);
        complete_fast("after_drop");

        // 6. Reset asserted mid-RESP clears everything immediately
        issue(3'b001, 32'h0000_6000, 32'hCAFE_F00D);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check("mid_busy", 64'(st_busy), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_busy", 64'(st_busy), 64'd0);
        check("arst_ready", 64'(st_ready), 64'd1);
        check("arst_addr", 64'(data_addr), 64'd0);
        check("arst_wstrb", 64'(data_wstrb), 64'd0);
        check("arst_wdata", 64'(data_wdata), 64'd0);
        step();
        resetn = 1'b1;
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        check("arst_nodone", 64'(st_done), 64'd0);
        check("arst_idle", 64'(st_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

endmodule
